// File: rtl/pipe_power_rate_ctrl_if.sv
// Command channel between the LTSSM and the PIPE power/rate sequencer.
//
// Signals:
//   req_valid       LTSSM -> ctrl  command request, held until accepted
//   req_ready       ctrl  -> LTSSM controller idle and able to accept
//   req_op          LTSSM -> ctrl  0 power, 1 rate, 2 receiver detect, 3 reserved
//   req_power_down  LTSSM -> ctrl  target power state for op 0
//   req_rate        LTSSM -> ctrl  target rate for op 1
//   done            ctrl  -> LTSSM one-cycle completion pulse
//   done_status     ctrl  -> LTSSM 0 ok, 1 timeout, 2 illegal (valid with done)
//   rx_detected     ctrl  -> LTSSM receiver-detect result (valid with done)
//
// Modports: master = LTSSM side, slave = controller side.
interface pipe_power_rate_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [3:0] req_power_down;
    logic [3:0] req_rate;
    logic       done;
    logic [1:0] done_status;
    logic       rx_detected;

    modport master (
        output req_valid, req_op, req_power_down, req_rate,
        input  req_ready, done, done_status, rx_detected
    );

    modport slave (
        input  req_valid, req_op, req_power_down, req_rate,
        output req_ready, done, done_status, rx_detected
    );
endinterface

// File: rtl/pipe_power_rate_ctrl.sv
// pipe_power_rate_ctrl: MAC-side sequencer for the PIPE handshake-driven
// controls (power state, link rate, receiver detect). One command at a time
// is taken from the LTSSM, the PIPE controls are driven, and the command
// completes on the PHY's phy_status pulse or on a bounded timeout.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   cmd             command channel (pipe_power_rate_ctrl_if.slave)
//   phy_status      PHY completion handshake
//   rx_status       PHY status; 3'b011 = receiver present
//   power_down, rate, pclk_rate, tx_elec_idle, tx_detect_rx : PIPE controls
//
// Parameters:
//   TIMEOUT_CYCLES  max WAIT cycles per command (4..65535)
//   P1_ENCODING     power_down encoding of P1 (reset state)
//
// Build option:
//   PIPE_CTRL_RXDET_EN  when defined, op 2 performs receiver detection;
//                       otherwise op 2 is rejected as illegal and
//                       tx_detect_rx is tied low.
//
// All outputs are registered: the output process computes next values and
// the register process loads them.
module pipe_power_rate_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [3:0]  P1_ENCODING    = 4'b0010
) (
    input  logic                   clk,
    input  logic                   reset,
    pipe_power_rate_ctrl_if.slave  cmd,
    input  logic                   phy_status,
    input  logic [2:0]             rx_status,
    output logic [3:0]             power_down,
    output logic [3:0]             rate,
    output logic [4:0]             pclk_rate,
    output logic [3:0]             tx_elec_idle,
    output logic                   tx_detect_rx
);
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_APPLY, S_WAIT, S_DONE} state_t;

    localparam logic [1:0]  OP_PWR   = 2'd0;
    localparam logic [1:0]  OP_RATE  = 2'd1;
    localparam logic [1:0]  OP_RXDET = 2'd2;
    localparam logic [1:0]  ST_OK    = 2'd0;
    localparam logic [1:0]  ST_TMO   = 2'd1;
    localparam logic [1:0]  ST_ILL   = 2'd2;
    // Last WAIT cycle index: WAIT starts with cnt=0, so the T-th wait cycle
    // sees cnt=T-1 and hands off to DONE.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [15:0] cnt_inc;
    logic [1:0]  op_q, op_nxt;
    logic [3:0]  eidle_save, eidle_save_nxt;
    logic [3:0]  power_down_nxt, rate_nxt, eidle_nxt;
    logic [4:0]  pclk_nxt;
    logic        ready_q, ready_nxt;
    logic        done_q, done_nxt;
    logic [1:0]  status_q, status_nxt;
    logic        rxd_q, rxd_nxt;
    logic        accept, op_legal, tmo_hit, wait_end;

`ifdef PIPE_CTRL_RXDET_EN
    logic        det_q, det_nxt;
    assign tx_detect_rx = det_q;
`else
    assign tx_detect_rx = 1'b0;
    logic unused_rx_status;
    assign unused_rx_status = ^rx_status;
`endif

    assign cmd.req_ready   = ready_q;
    assign cmd.done        = done_q;
    assign cmd.done_status = status_q;
    assign cmd.rx_detected = rxd_q;

    assign accept   = cmd.req_valid && ready_q;
    assign cnt_inc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign tmo_hit  = (cnt >= TMO_LAST);
    assign wait_end = phy_status || tmo_hit;

    // Legality is judged against the power state in force at accept time.
    always_comb begin
        op_legal = 1'b0;
        case (cmd.req_op)
            OP_PWR:  op_legal = 1'b1;
            OP_RATE: op_legal = (power_down == 4'b0000);
            OP_RXDET: begin
`ifdef PIPE_CTRL_RXDET_EN
                op_legal = (power_down == P1_ENCODING);
`else
                op_legal = 1'b0;
`endif
            end
            default: op_legal = 1'b0;
        endcase
    end

    // Register process: FSM state plus every output/datapath register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_INIT;
            cnt          <= 16'd0;
            op_q         <= OP_PWR;
            eidle_save   <= 4'hF;
            power_down   <= P1_ENCODING;
            rate         <= 4'd0;
            pclk_rate    <= 5'd0;
            tx_elec_idle <= 4'hF;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            status_q     <= ST_OK;
            rxd_q        <= 1'b0;
`ifdef PIPE_CTRL_RXDET_EN
            det_q        <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            op_q         <= op_nxt;
            eidle_save   <= eidle_save_nxt;
            power_down   <= power_down_nxt;
            rate         <= rate_nxt;
            pclk_rate    <= pclk_nxt;
            tx_elec_idle <= eidle_nxt;
            ready_q      <= ready_nxt;
            done_q       <= done_nxt;
            status_q     <= status_nxt;
            rxd_q        <= rxd_nxt;
`ifdef PIPE_CTRL_RXDET_EN
            det_q        <= det_nxt;
`endif
        end
    end

    // Next-state process.
    always_comb begin
        state_nxt = state;
        case (state)
            // cnt counts consecutive low phy_status cycles here.
            S_INIT:  if (!phy_status && cnt != 16'd0) state_nxt = S_IDLE;
            S_IDLE:  if (accept) state_nxt = op_legal ? S_APPLY : S_DONE;
            S_APPLY: state_nxt = S_WAIT;
            S_WAIT:  if (wait_end) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_INIT;
        endcase
    end

    // Output process: next values for the registered outputs.
    always_comb begin
        cnt_nxt        = cnt;
        op_nxt         = op_q;
        eidle_save_nxt = eidle_save;
        power_down_nxt = power_down;
        rate_nxt       = rate;
        pclk_nxt       = pclk_rate;
        eidle_nxt      = tx_elec_idle;
        ready_nxt      = (state_nxt == S_IDLE);
        done_nxt       = 1'b0;
        status_nxt     = status_q;
        rxd_nxt        = rxd_q;
`ifdef PIPE_CTRL_RXDET_EN
        det_nxt        = det_q;
`endif
        case (state)
            S_INIT: cnt_nxt = phy_status ? 16'd0 : cnt_inc;
            S_IDLE: begin
                if (accept) begin
                    op_nxt = cmd.req_op;
                    if (op_legal) begin
                        case (cmd.req_op)
                            OP_PWR: power_down_nxt = cmd.req_power_down;
                            OP_RATE: begin
                                // Electrical idle is forced for the whole rate
                                // change and the previous value put back at the end.
                                eidle_save_nxt = tx_elec_idle;
                                eidle_nxt      = 4'hF;
                                rate_nxt       = cmd.req_rate;
                                pclk_nxt       = {1'b0, cmd.req_rate};
                            end
                            default: begin
`ifdef PIPE_CTRL_RXDET_EN
                                det_nxt = 1'b1;
`endif
                            end
                        endcase
                    end else begin
                        done_nxt   = 1'b1;
                        status_nxt = ST_ILL;
                        rxd_nxt    = 1'b0;
                    end
                end
            end
            S_APPLY: cnt_nxt = 16'd0;
            S_WAIT: begin
                cnt_nxt = cnt_inc;
                if (wait_end) begin
                    // phy_status wins over a timeout landing on the same cycle.
                    done_nxt   = 1'b1;
                    status_nxt = phy_status ? ST_OK : ST_TMO;
                    rxd_nxt    = 1'b0;
`ifdef PIPE_CTRL_RXDET_EN
                    det_nxt    = 1'b0;
                    if (phy_status && op_q == OP_RXDET)
                        rxd_nxt = (rx_status == 3'b011);
`endif
                    if (op_q == OP_RATE) eidle_nxt = eidle_save;
                end
            end
            default: ;
        endcase
    end
endmodule
